// File: rtl/div_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_arbiter
// Two-requester front end for a shared 8-bit signed restoring divider.
// One operand pair is accepted at a time; the result is held on the response
// port until the consumer takes it.
//
// Parameters
//   RR_EN         1 = round-robin between requesters, 0 = requester 0 always wins
// Ports
//   i_clk         clock, all state updates on rising edge
//   i_rst         synchronous active-high reset
//   i_reqN_valid  requester N has an operand pair (N = 0,1)
//   i_reqN_q/m    requester N signed dividend / divisor
//   o_reqN_ready  requester N operands accepted this cycle (valid & ready)
//   o_rsp_valid   result held on the response outputs
//   i_rsp_ready   consumer takes the result (valid & ready)
//   o_rsp_id      requester that owns the result
//   o_quo/o_rem   signed quotient / remainder (truncation toward zero)
//   o_dz/o_ovf    divide-by-zero / quotient overflow (-128 / -1)
//   o_busy        high whenever an operation is in progress or held
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_q,
  input  logic [7:0] i_req0_m,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_q,
  input  logic [7:0] i_req1_m,
  output logic       o_req1_ready,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_id,
  output logic [7:0] o_quo,
  output logic [7:0] o_rem,
  output logic       o_dz,
  output logic       o_ovf,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [7:0] neg8(input logic [7:0] a);
    return (~a) + 8'd1;
  endfunction

  // -128 maps to 0x80, which is the correct unsigned magnitude.
  function automatic logic [7:0] abs8(input logic [7:0] a);
    return a[7] ? neg8(a) : a;
  endfunction

  state_t     state_q, state_d;
  logic       last_q, last_d;          // last granted requester
  logic       id_q, id_d;              // owner of the in-flight operation
  logic       q_sign_q, q_sign_d;
  logic       m_sign_q, m_sign_d;
  logic       dz_pend_q, dz_pend_d;
  logic       ovf_pend_q, ovf_pend_d;
  logic [7:0] q_raw_q, q_raw_d;        // original dividend, returned on divide-by-zero
  logic [7:0] m_mag_q, m_mag_d;
  logic [8:0] prem_q, prem_d;          // partial remainder
  logic [7:0] dq_q, dq_d;              // dividend bits shift out, quotient bits shift in
  logic [2:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_id_q, rsp_id_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] rem_q, rem_d;
  logic       dz_q, dz_d;
  logic       ovf_q, ovf_d;

  logic       grant_any_s;
  logic       grant_id_s;
  logic       accept_s;
  logic [7:0] q_sel_s;
  logic [7:0] m_sel_s;
  logic [8:0] shift_s;
  logic [9:0] trial_s;
  logic       unused_s;

  // Grant selection among the currently valid requesters.
  always_comb begin
    grant_any_s = i_req0_valid | i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      if (RR_EN) begin
        grant_id_s = ~last_q;
      end else begin
        grant_id_s = 1'b0;
      end
    end else if (i_req0_valid) begin
      grant_id_s = 1'b0;
    end else begin
      grant_id_s = 1'b1;
    end
  end

  assign accept_s     = (state_q == IDLE) && !i_rst && grant_any_s;
  assign o_req0_ready = accept_s && !grant_id_s;
  assign o_req1_ready = accept_s && grant_id_s;

  assign q_sel_s = grant_id_s ? i_req1_q : i_req0_q;
  assign m_sel_s = grant_id_s ? i_req1_m : i_req0_m;

  // The kept remainder is always below |m| <= 0x80, so bit 8 stays 0 between
  // steps; only the shifted trial value needs the full 9 bits.
  assign shift_s  = {prem_q[7:0], dq_q[7]};
  assign trial_s  = {1'b0, shift_s} - {2'b00, m_mag_q};
  assign unused_s = prem_q[8];

  // Next-state and datapath computation for the divider FSM.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    q_sign_d    = q_sign_q;
    m_sign_d    = m_sign_q;
    dz_pend_d   = dz_pend_q;
    ovf_pend_d  = ovf_pend_q;
    q_raw_d     = q_raw_q;
    m_mag_d     = m_mag_q;
    prem_d      = prem_q;
    dq_d        = dq_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          id_d       = grant_id_s;
          last_d     = grant_id_s;
          q_raw_d    = q_sel_s;
          q_sign_d   = q_sel_s[7];
          m_sign_d   = m_sel_s[7];
          m_mag_d    = abs8(m_sel_s);
          dq_d       = abs8(q_sel_s);
          prem_d     = 9'd0;
          cnt_d      = 3'd0;
          dz_pend_d  = (m_sel_s == 8'h00);
          ovf_pend_d = (q_sel_s == 8'h80) && (m_sel_s == 8'hFF);
          if (m_sel_s == 8'h00) begin
            state_d = FIX;
          end else begin
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end

      DIV: begin
        // trial_s[9] set means the subtraction went negative: restore.
        if (!trial_s[9]) begin
          prem_d = trial_s[8:0];
          dq_d   = {dq_q[6:0], 1'b1};
        end else begin
          prem_d = shift_s;
          dq_d   = {dq_q[6:0], 1'b0};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = FIX;
        end else begin
          state_d = DIV;
        end
      end

      FIX: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        state_d     = DONE;
        if (dz_pend_q) begin
          quo_d = 8'hFF;
          rem_d = q_raw_q;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else if (ovf_pend_q) begin
          quo_d = 8'h80;
          rem_d = 8'h00;
          dz_d  = 1'b0;
          ovf_d = 1'b1;
        end else begin
          quo_d = (q_sign_q ^ m_sign_q) ? neg8(dq_q) : dq_q;
          rem_d = q_sign_q ? neg8(prem_q[7:0]) : prem_q[7:0];
          dz_d  = 1'b0;
          ovf_d = 1'b0;
        end
      end

      DONE: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      q_sign_q    <= 1'b0;
      m_sign_q    <= 1'b0;
      dz_pend_q   <= 1'b0;
      ovf_pend_q  <= 1'b0;
      q_raw_q     <= 8'h00;
      m_mag_q     <= 8'h00;
      prem_q      <= 9'd0;
      dq_q        <= 8'h00;
      cnt_q       <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      quo_q       <= 8'h00;
      rem_q       <= 8'h00;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      q_sign_q    <= q_sign_d;
      m_sign_q    <= m_sign_d;
      dz_pend_q   <= dz_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      q_raw_q     <= q_raw_d;
      m_mag_q     <= m_mag_d;
      prem_q      <= prem_d;
      dq_q        <= dq_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_quo       = quo_q;
  assign o_rem       = rem_q;
  assign o_dz        = dz_q;
  assign o_ovf       = ovf_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_div_arbiter
// Directed bench for div_arbiter. Two instances share all inputs: dut_rr uses
// round-robin arbitration, dut_fp fixed priority. Inputs change and outputs are
// sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_div_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rsp_ready;
  logic [7:0] q0, m0, q1, m1;

  logic       rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_dz, rr_ovf, rr_busy;
  logic [7:0] rr_quo, rr_rem;
  logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_dz, fp_ovf, fp_busy;
  logic [7:0] fp_quo, fp_rem;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] q;
    logic [7:0] m;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dz;
    logic       ovf;
    logic [3:0] lat;
  } vec_t;

  always #5 clk = ~clk;

  div_arbiter #(.RR_EN(1'b1)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_q(q0), .i_req0_m(m0), .o_req0_ready(rr_req0_ready),
    .i_req1_valid(v1), .i_req1_q(q1), .i_req1_m(m1), .o_req1_ready(rr_req1_ready),
    .o_rsp_valid(rr_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rr_rsp_id),
    .o_quo(rr_quo), .o_rem(rr_rem), .o_dz(rr_dz), .o_ovf(rr_ovf), .o_busy(rr_busy)
  );

  div_arbiter #(.RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_q(q0), .i_req0_m(m0), .o_req0_ready(fp_req0_ready),
    .i_req1_valid(v1), .i_req1_q(q1), .i_req1_m(m1), .o_req1_ready(fp_req1_ready),
    .o_rsp_valid(fp_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(fp_rsp_id),
    .o_quo(fp_quo), .o_rem(fp_rem), .o_dz(fp_dz), .o_ovf(fp_ovf), .o_busy(fp_busy)
  );

  // Present one operand pair on requester id until it is accepted.
  task automatic send(input logic id, input logic [7:0] q, input logic [7:0] m);
    int ok;
    ok = 0;
    @(negedge clk);
    if (id == 1'b0) begin v0 = 1'b1; q0 = q; m0 = m; end
    else            begin v1 = 1'b1; q1 = q; m1 = m; end
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((id == 1'b0 && rr_req0_ready) || (id == 1'b1 && rr_req1_ready)) begin
        ok = 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (ok == 0) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: got no ready for req%0d, want ready within 20 cycles", id);
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  // Count edges after acceptance until the response appears.
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (rr_rsp_valid) break;
      n++;
    end
    if (!rr_rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: got rsp_valid=0, want 1 within 40 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    v0 = 1'b1; q0 = 8'h14; m0 = 8'h03;
    v1 = 1'b1; q1 = 8'h32; m1 = 8'h05;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (rr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", rr_busy); end
    vectors++; if (rr_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rr_rsp_valid); end
    vectors++; if ({rr_quo, rr_rem} !== 16'h0000) begin miscompares++; $display("FAIL reset_quo_rem: got %h want 0000", {rr_quo, rr_rem}); end
    vectors++; if ({rr_rsp_id, rr_dz, rr_ovf} !== 3'b000) begin miscompares++; $display("FAIL reset_id_flags: got %b want 000", {rr_rsp_id, rr_dz, rr_ovf}); end
    vectors++; if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0000", {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready});
    end
    v0 = 1'b0; v1 = 1'b0; rst = 1'b0;
  endtask

  task automatic test_divide();
    vec_t tbl [10];
    int n;
    tbl = '{
      '{1'b0, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 4'd9},   //  100 /  7
      '{1'b0, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 4'd9},   // -100 /  7
      '{1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 4'd9},   //  100 / -7
      '{1'b0, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 4'd9},   // -100 / -7
      '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 4'd9},   // -128 /  1
      '{1'b0, 8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 4'd9},   //  127 / -128
      '{1'b1, 8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 4'd9},   // -128 / -128
      '{1'b1, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 4'd1},   //    5 /  0
      '{1'b0, 8'h9C, 8'h00, 8'hFF, 8'h9C, 1'b1, 1'b0, 4'd1},   // -100 /  0
      '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 4'd9}    // -128 / -1
    };
    rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].id, tbl[i].q, tbl[i].m);
      wait_rsp(n);
      vectors++; if (n !== int'(tbl[i].lat)) begin miscompares++; $display("FAIL div[%0d]_latency: got %0d want %0d", i, n, tbl[i].lat); end
      vectors++; if (rr_rsp_id !== tbl[i].id) begin miscompares++; $display("FAIL div[%0d]_id: got %b want %b", i, rr_rsp_id, tbl[i].id); end
      vectors++; if (rr_quo !== tbl[i].quo) begin miscompares++; $display("FAIL div[%0d]_quo: got %h want %h", i, rr_quo, tbl[i].quo); end
      vectors++; if (rr_rem !== tbl[i].rem) begin miscompares++; $display("FAIL div[%0d]_rem: got %h want %h", i, rr_rem, tbl[i].rem); end
      vectors++; if ({rr_dz, rr_ovf} !== {tbl[i].dz, tbl[i].ovf}) begin
        miscompares++; $display("FAIL div[%0d]_flags: got dz,ovf=%b want %b", i, {rr_dz, rr_ovf}, {tbl[i].dz, tbl[i].ovf});
      end
      vectors++; if ({fp_rsp_valid, fp_rsp_id, fp_quo, fp_rem, fp_dz, fp_ovf} !== {1'b1, tbl[i].id, tbl[i].quo, tbl[i].rem, tbl[i].dz, tbl[i].ovf}) begin
        miscompares++; $display("FAIL div[%0d]_fp: got %h want %h", i, {fp_rsp_valid, fp_rsp_id, fp_quo, fp_rem, fp_dz, fp_ovf},
                                {1'b1, tbl[i].id, tbl[i].quo, tbl[i].rem, tbl[i].dz, tbl[i].ovf});
      end
      @(negedge clk); #1;
      vectors++; if ({rr_rsp_valid, rr_busy} !== 2'b00) begin miscompares++; $display("FAIL div[%0d]_release: got valid,busy=%b want 00", i, {rr_rsp_valid, rr_busy}); end
      vectors++; if (rr_quo !== tbl[i].quo) begin miscompares++; $display("FAIL div[%0d]_hold: got %h want %h", i, rr_quo, tbl[i].quo); end
    end
  endtask

  task automatic test_arbitration();
    int   found;
    int   n;
    logic last_g;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    q0 = 8'h14; m0 = 8'h03;   // 20 / 3 = 6 r 2
    q1 = 8'h32; m1 = 8'h05;   // 50 / 5 = 10 r 0
    v0 = 1'b1; v1 = 1'b1;
    last_g = 1'b0;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk); #1;
        vectors++; if (rr_req0_ready && rr_req1_ready) begin miscompares++; $display("FAIL arb_both_ready: got 11 want at most one"); end
        vectors++; if ((rr_req0_ready || rr_req1_ready) && rr_busy) begin miscompares++; $display("FAIL arb_ready_busy: got ready while busy, want none"); end
        if (rr_rsp_valid) begin
          vectors++; if (rr_rsp_id !== last_g) begin miscompares++; $display("FAIL arb_rsp_id: got %b want %b", rr_rsp_id, last_g); end
          vectors++; if ({rr_quo, rr_rem} !== (last_g ? 16'h0A00 : 16'h0602)) begin
            miscompares++; $display("FAIL arb_rsp_data: got %h want %h", {rr_quo, rr_rem}, (last_g ? 16'h0A00 : 16'h0602));
          end
        end
        if (rr_req0_ready || rr_req1_ready) begin
          found = 1;
          break;
        end
      end
      vectors++; if (found == 0) begin miscompares++; $display("FAIL arb_timeout[%0d]: got no grant want grant", g); end
      vectors++; if (rr_req1_ready !== g[0]) begin miscompares++; $display("FAIL rr_order[%0d]: got req%0d want req%0d", g, rr_req1_ready, g[0]); end
      vectors++; if ({fp_req0_ready, fp_req1_ready} !== 2'b10) begin miscompares++; $display("FAIL fp_order[%0d]: got ready=%b want 10", g, {fp_req0_ready, fp_req1_ready}); end
      last_g = rr_req1_ready;
      @(posedge clk);
    end
    #1 v0 = 1'b0; v1 = 1'b0;
    wait_rsp(n);
    vectors++; if ({rr_rsp_id, rr_quo, rr_rem} !== {1'b1, 16'h0A00}) begin
      miscompares++; $display("FAIL arb_last_rsp: got %h want %h", {rr_rsp_id, rr_quo, rr_rem}, {1'b1, 16'h0A00});
    end
    @(negedge clk); #1;
  endtask

  task automatic test_back_pressure();
    int n;
    rsp_ready = 1'b0;
    send(1'b1, 8'h9C, 8'hF9);  // -100 / -7
    wait_rsp(n);
    vectors++; if (n !== 9) begin miscompares++; $display("FAIL bp_latency: got %0d want 9", n); end
    q0 = 8'h14; m0 = 8'h03; q1 = 8'h32; m1 = 8'h05;
    v0 = 1'b1; v1 = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      vectors++; if ({rr_rsp_valid, rr_busy, rr_rsp_id, rr_quo, rr_rem} !== {3'b111, 16'h0EFE}) begin
        miscompares++; $display("FAIL bp_stable[%0d]: got %h want %h", i, {rr_rsp_valid, rr_busy, rr_rsp_id, rr_quo, rr_rem}, {3'b111, 16'h0EFE});
      end
      vectors++; if ({rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready, fp_busy} !== 5'b00001) begin
        miscompares++; $display("FAIL bp_no_accept[%0d]: got %b want 00001", i, {rr_req0_ready, rr_req1_ready, fp_req0_ready, fp_req1_ready, fp_busy});
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++; if ({rr_req0_ready, rr_req1_ready} !== 2'b00) begin miscompares++; $display("FAIL bp_release_cycle: got ready=%b want 00", {rr_req0_ready, rr_req1_ready}); end
    @(negedge clk); #1;
    vectors++; if ({rr_rsp_valid, rr_busy} !== 2'b00) begin miscompares++; $display("FAIL bp_idle: got valid,busy=%b want 00", {rr_rsp_valid, rr_busy}); end
    vectors++; if ({rr_req0_ready, rr_req1_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant: got ready=%b want 10", {rr_req0_ready, rr_req1_ready}); end
    v0 = 1'b0; v1 = 1'b0;
    vectors++; if (rr_quo !== 8'h0E) begin miscompares++; $display("FAIL bp_hold: got %h want 0e", rr_quo); end
  endtask

  task automatic test_reset_mid();
    int n;
    rsp_ready = 1'b1;
    send(1'b0, 8'h64, 8'h07);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    v0 = 1'b1; q0 = 8'h9C; m0 = 8'h07;
    v1 = 1'b1; q1 = 8'h64; m1 = 8'hF9;
    @(negedge clk); #1;
    vectors++; if ({rr_busy, rr_rsp_valid, rr_rsp_id, rr_dz, rr_ovf} !== 5'b00000) begin
      miscompares++; $display("FAIL rm_state: got busy,valid,id,dz,ovf=%b want 00000", {rr_busy, rr_rsp_valid, rr_rsp_id, rr_dz, rr_ovf});
    end
    vectors++; if ({rr_quo, rr_rem} !== 16'h0000) begin miscompares++; $display("FAIL rm_data: got %h want 0000", {rr_quo, rr_rem}); end
    vectors++; if ({rr_req0_ready, rr_req1_ready} !== 2'b00) begin miscompares++; $display("FAIL rm_ready_in_reset: got %b want 00", {rr_req0_ready, rr_req1_ready}); end
    rst = 1'b0;
    #1;
    vectors++; if ({rr_req0_ready, rr_req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rm_grant: got ready=%b want 10", {rr_req0_ready, rr_req1_ready}); end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
    wait_rsp(n);
    vectors++; if (n !== 9) begin miscompares++; $display("FAIL rm_latency: got %0d want 9", n); end
    vectors++; if ({rr_rsp_id, rr_quo, rr_rem} !== {1'b0, 16'hF2FE}) begin
      miscompares++; $display("FAIL rm_result: got %h want %h", {rr_rsp_id, rr_quo, rr_rem}, {1'b0, 16'hF2FE});
    end
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    q0 = 8'h00; m0 = 8'h00; q1 = 8'h00; m1 = 8'h00;
    test_reset();
    test_divide();
    test_arbitration();
    test_back_pressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1);
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with requester 0 always winning.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_req0_valid  in  1  requester 0 has an operand pair.
REQ-005 i_req0_q / i_req0_m  in  8 each  requester 0 signed dividend / divisor (two's complement).
REQ-006 o_req0_ready  out  1  requester 0 operands accepted this cycle when valid&ready.
REQ-007 i_req1_valid, i_req1_q, i_req1_m, o_req1_ready: same as REQ-004..006, for requester 1.
REQ-008 o_rsp_valid  out  1  result held on response outputs.
REQ-009 i_rsp_ready  in  1  consumer takes the result when valid&ready.
REQ-010 o_rsp_id  out  1  index of the requester that owns the result.
REQ-011 o_quo / o_rem  out  8 each  signed quotient / remainder.
REQ-012 o_dz / o_ovf  out  1 each  divide-by-zero flag / quotient overflow flag.
REQ-013 o_busy  out  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, DIV, FIX, DONE.
REQ-015 o_reqN_ready SHALL be combinational: high only in IDLE and only for the granted requester; at most one ready is high per cycle. Ready SHALL not wait for the other requester.
REQ-016 Grant: if exactly one valid, that requester wins. If both are valid and RR_EN=1, the requester not granted last wins; after reset the last-grant pointer is 1, so requester 0 wins first. If both are valid and RR_EN=0, requester 0 wins.
REQ-017 On acceptance the block SHALL capture the operands, sign bits, and requester id, and load magnitudes |q| and |m| as 8-bit unsigned values (-128 maps to 0x80). The last-grant pointer updates to the accepted id.
REQ-018 Divisor zero at acceptance: go straight to FIX, with no iterations.
REQ-019 DIV: one restoring-division step per cycle, exactly 8 cycles. Each step: shift the partial remainder left and bring in the dividend MSB, then subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0. Use a 9-bit partial remainder so |m|=0x80 is exact.
REQ-020 FIX (1 cycle): the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero). Outputs are registered and the state moves to DONE.
REQ-021 Divide-by-zero: o_quo=0xFF, o_rem=dividend, o_dz=1, o_ovf=0.
REQ-022 Overflow, only for -128/-1: o_quo=0x80, o_rem=0x00, o_ovf=1.
REQ-023 Latency: if acceptance is at edge k, o_rsp_valid SHALL rise after edge k+9 for normal operands and after edge k+1 for a zero divisor.
REQ-024 DONE: o_rsp_valid=1. The response outputs SHALL stay stable until the edge where i_rsp_ready=1, then return to IDLE. There is no new acceptance in that same cycle; the earliest next acceptance is the following cycle.
REQ-025 Requester inputs SHALL be ignored outside IDLE, and a requester's valid may drop without penalty while not granted.
REQ-026 When not in DONE, o_quo, o_rem, o_dz, o_ovf, and o_rsp_id SHALL hold their last values.

Reset
REQ-027 i_rst=1 at an edge SHALL force IDLE, last-grant pointer=1, and o_rsp_valid=0. It SHALL also clear o_quo, o_rem, o_rsp_id, o_dz, and o_ovf to 0.
REQ-028 Reset SHALL take precedence over every other event, including mid-DIV or in DONE. The in-flight operation is discarded and no response is produced for it.
REQ-029 o_reqN_ready SHALL be 0 during any cycle in which i_rst=1.

Verification
REQ-030 Req0 q=100 (0x64), m=7, i_rsp_ready=1 -> id=0, quo=0x0E, rem=0x02, flags 0, rsp_valid 9 cycles after acceptance.
REQ-031 Sign cases -> -100/7 gives quo=0xF2, rem=0xFE; 100/-7 gives quo=0xF2, rem=0x02; -100/-7 gives quo=0x0E, rem=0xFE; -128/1 gives quo=0x80, rem=0x00.
REQ-032 Req1 q=0x05, m=0 -> o_dz=1, quo=0xFF, rem=0x05, rsp_valid 1 cycle after acceptance; and q=0x80, m=0xFF -> o_ovf=1, quo=0x80, rem=0x00.
REQ-033 Both valid continuously, RR_EN=1 -> grants in order 0,1,0,1; with RR_EN=0 -> grants in order 0,0,0. Ready is never high for both, and never high outside IDLE.
REQ-034 Backpressure: hold i_rsp_ready=0 for 5 cycles in DONE -> outputs stable, no acceptance; release -> IDLE next edge.
REQ-035 Reset mid-operation: assert i_rst at the 4th DIV cycle -> next cycle IDLE, all outputs 0, no response. The next request then gets its correct result, and requester 0 is granted if both requesters are valid.
